tl_egress_drain: RTL and testbench
==================================

TL_EGRESS_DRAIN -- requirements
Module: tl_egress_drain

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_L  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: init  in  1  high = hold in INIT, clear counters, no pops.
REQ-004 SHALL have ports: empty_in  in  4  per-output-FIFO empty flag, bit N = FIFO N.
REQ-005 SHALL have ports: data_in0..data_in3  in  10 each  first-word-fall-through head of FIFO N, valid while empty_in[N]=0.
REQ-006 SHALL have port: pop_out  out  4  one-hot pop to FIFO N, consumes head that cycle.
REQ-007 SHALL have ports: data_out  out  10  merged egress word; valid_out  out  1; ready_in  in  1  downstream accept.
REQ-008 SHALL have ports: req  in  1, idx  in  2  counter read request and index.
REQ-009 SHALL have ports: contador  out  5  read value; contador_valid  out  1  read strobe.
REQ-010 SHALL have port: err_route  out  4  sticky per-FIFO routing error.

Function
REQ-011 SHALL implement FSM states RESET, INIT, IDLE, ACTIVE.
REQ-012 RESET->INIT on first edge after reset_L deasserts; INIT->IDLE when init=0; any state->INIT when init=1.
REQ-013 IDLE->ACTIVE when any empty_in bit is 0; ACTIVE->IDLE when all empty_in=1 and output register empty.
REQ-014 Output register "free" = valid_out=0, or valid_out=1 and ready_in=1 this cycle.
REQ-015 In ACTIVE with register free, SHALL assert exactly one pop_out bit for a non-empty FIFO, selected per REQ-016 or REQ-024.
REQ-016 Default selection: fixed priority FIFO0 > FIFO1 > FIFO2 > FIFO3.
REQ-017 Popped word SHALL appear on data_out with valid_out=1 on the next cycle (latency 1); throughput 1 word/cycle when ready_in=1.
REQ-018 valid_out=1 with ready_in=0: data_out and valid_out held stable, pop_out=0.
REQ-019 pop_out SHALL never assert to a FIFO with empty_in=1, nor in RESET/INIT/IDLE.
REQ-020 Per-FIFO 5-bit word counter increments on each pop of that FIFO; wraps 31->0.
REQ-021 req=1 SHALL register counter[idx] to contador and pulse contador_valid for one cycle, next cycle; read and pop of same FIFO in same cycle returns pre-increment value.
REQ-022 On pop of FIFO N, data_in N bits [9:8] != N SHALL set err_route[N]; cleared only by reset or INIT; word still forwarded.

Reset
REQ-023 reset_L=0 SHALL immediately force state=RESET, pop_out=0, data_out=0, valid_out=0, contador=0, contador_valid=0, err_route=0, all counters=0; in-flight word discarded.

Configuration
REQ-024 With TL_DRAIN_RR_EN defined, selection SHALL be round-robin starting after last-popped FIFO (reset pointer = FIFO3, so FIFO0 first); without it, REQ-016 fixed priority applies.

Structure
REQ-025 Shared package tl_drain_pkg SHALL hold FSM state enum, WORD_W=10, CNT_W=5, NUM_FIFO=4, DEST field position [9:8].
REQ-026 Selection logic SHALL be one sub-module tl_drain_arbiter (empty_in, enable, pointer -> one-hot grant).

Verification
REQ-027 Reset, init 1->0, FIFO0 holds 0x001 only, ready_in=1 -> pop_out=0001 once, data_out=0x001 valid_out=1 next cycle, state returns IDLE.
REQ-028 All four FIFOs hold 2 words each (dest-correct), ready_in=1, macro off -> egress order F0,F0,F1,F1,F2,F2,F3,F3 with no gaps.
REQ-029 Same stimulus, TL_DRAIN_RR_EN defined -> order F0,F1,F2,F3,F0,F1,F2,F3.
REQ-030 ready_in=0 for 3 cycles with valid_out=1 -> data_out stable, pop_out=0 throughout; pops resume the cycle ready_in=1.
REQ-031 33 pops of FIFO2, then req=1 idx=2 -> contador=1, contador_valid one pulse; idx=0 unused -> 0.
REQ-032 FIFO1 head 0x301 popped -> err_route=0010 sticky until init=1; mid-stream reset_L=0 -> all outputs 0 same cycle.

Source files
------------

// File: rtl/tl_drain_pkg.sv
// Shared types and sizes for the egress drain block.
// FSM encoding, word/counter widths and the routing field position.
package tl_drain_pkg;

  localparam int WORD_W   = 10;
  localparam int CNT_W    = 5;
  localparam int NUM_FIFO = 4;
  localparam int IDX_W    = 2;
  localparam int DEST_HI  = 9;
  localparam int DEST_LO  = 8;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [NUM_FIFO-1:0] oh
  );
    oh2idx = '0;
    for (int i = 0; i < NUM_FIFO; i++)
      if (oh[i]) oh2idx = IDX_W'(i);
  endfunction

endpackage

// File: rtl/tl_drain_arbiter.sv
// One-hot grant to the first non-empty FIFO searching after ptr.
// With ptr held at the last index this is plain fixed priority.
module tl_drain_arbiter
  import tl_drain_pkg::*;
(
  input  logic [NUM_FIFO-1:0] empty_in,
  input  logic                enable,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_FIFO-1:0] grant
);

  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      pos = ptr + IDX_W'(k + 1);
      if (enable && !found && !empty_in[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_egress_drain.sv
// Drains four FWFT FIFOs into one registered egress stream.
// TL_DRAIN_RR_EN selects round-robin instead of fixed priority.
module tl_egress_drain
  import tl_drain_pkg::*;
(
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [NUM_FIFO-1:0] empty_in,
  input  logic [WORD_W-1:0]   data_in0,
  input  logic [WORD_W-1:0]   data_in1,
  input  logic [WORD_W-1:0]   data_in2,
  input  logic [WORD_W-1:0]   data_in3,
  output logic [NUM_FIFO-1:0] pop_out,
  output logic [WORD_W-1:0]   data_out,
  output logic                valid_out,
  input  logic                ready_in,
  input  logic                req,
  input  logic [IDX_W-1:0]    idx,
  output logic [CNT_W-1:0]    contador,
  output logic                contador_valid,
  output logic [NUM_FIFO-1:0] err_route
);

  state_t              state;
  state_t              state_nx;
  logic [NUM_FIFO-1:0] grant;
  logic [IDX_W-1:0]    ptr;
  logic [WORD_W-1:0]   din [NUM_FIFO];
  logic [WORD_W-1:0]   pop_data;
  logic [CNT_W-1:0]    cnt [NUM_FIFO];
  logic                reg_free;
  logic                run;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  assign reg_free = !valid_out || ready_in;
  assign run      = (state == ST_ACTIVE) && !init && reg_free;
  assign pop_out  = grant;

  tl_drain_arbiter u_arb (
    .empty_in (empty_in),
    .enable   (run),
    .ptr      (ptr),
    .grant    (grant)
  );

  always_comb begin
    pop_data = '0;
    for (int n = 0; n < NUM_FIFO; n++)
      if (grant[n]) pop_data = pop_data | din[n];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RESET:  state_nx = ST_INIT;
      ST_INIT:   if (!init) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (init)             state_nx = ST_INIT;
        else if (!(&empty_in)) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                         state_nx = ST_INIT;
        else if (&empty_in && !valid_out) state_nx = ST_IDLE;
      end
      default:   state_nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_RESET;
    else          state <= state_nx;
  end

  // Word is only taken when the register is free, so it is never overwritten.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (init) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (reg_free) begin
      valid_out <= |grant;
      if (|grant) data_out <= pop_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int n = 0; n < NUM_FIFO; n++) cnt[n] <= '0;
      err_route <= '0;
      ptr       <= IDX_W'(NUM_FIFO - 1);
    end else if (init) begin
      for (int n = 0; n < NUM_FIFO; n++) cnt[n] <= '0;
      err_route <= '0;
      ptr       <= IDX_W'(NUM_FIFO - 1);
    end else begin
      for (int n = 0; n < NUM_FIFO; n++) begin
        if (grant[n]) begin
          cnt[n] <= cnt[n] + 1'b1;
          if (din[n][DEST_HI:DEST_LO] != IDX_W'(n))
            err_route[n] <= 1'b1;
        end
      end
`ifdef TL_DRAIN_RR_EN
      if (|grant) ptr <= oh2idx(grant);
`else
      ptr <= IDX_W'(NUM_FIFO - 1);
`endif
    end
  end

  // Register read sees the counter before this cycle's increment.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      contador       <= '0;
      contador_valid <= 1'b0;
    end else begin
      contador_valid <= req;
      if (req) contador <= cnt[idx];
    end
  end

endmodule

// File: tb/tb_tl_egress_drain.sv
// Scoreboard bench for tl_egress_drain: FIFO model drives heads,
// expected egress words are queued at load time and popped on handshake.
module tb_tl_egress_drain;
  import tl_drain_pkg::*;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [3:0] empty_in;
  logic [9:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0] pop_out;
  logic [9:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       req;
  logic [1:0] idx;
  logic [4:0] contador;
  logic       contador_valid;
  logic [3:0] err_route;

  always #5 clk = ~clk;

  tl_egress_drain dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .init           (init),
    .empty_in       (empty_in),
    .data_in0       (data_in0),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_in3       (data_in3),
    .pop_out        (pop_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .req            (req),
    .idx            (idx),
    .contador       (contador),
    .contador_valid (contador_valid),
    .err_route      (err_route)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [9:0] fq [4][$];
  logic [9:0] exp_q [$];
  logic [3:0] s_pop;
  logic       s_valid;
  logic [9:0] s_data;
  logic       s_cv;
  logic [4:0] s_cnt;
  logic       prev_pop;
  int pop_cnt [4];
  int hs_n, hs_first, hs_last;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive();
    logic [9:0] h [4];
    for (int n = 0; n < 4; n++) begin
      empty_in[n] = (fq[n].size() == 0);
      h[n] = (fq[n].size() == 0) ? 10'h000 : fq[n][0];
    end
    data_in0 = h[0];
    data_in1 = h[1];
    data_in2 = h[2];
    data_in3 = h[3];
  endtask

  task automatic cycle();
    logic [9:0] e;
    @(negedge clk);
    s_pop   = pop_out;
    s_valid = valid_out;
    s_data  = data_out;
    s_cv    = contador_valid;
    s_cnt   = contador;
    if (prev_pop) check("latency_valid", s_valid, 1);
    if (s_pop != 0)
      check("pop_legal", ((s_pop & empty_in) == 0) && $onehot(s_pop), 1);
    if (s_valid && ready_in) begin
      check("egress_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("egress_data", s_data, e);
      end
      if (hs_n == 0) hs_first = cyc;
      hs_last = cyc;
      hs_n++;
    end
    prev_pop = (s_pop != 0);
    for (int n = 0; n < 4; n++) if (s_pop[n]) pop_cnt[n]++;
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 4; n++)
      if (s_pop[n] && fq[n].size() > 0) void'(fq[n].pop_front());
    drive();
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((exp_q.size() != 0 || valid_out) && k < bound) begin
      cycle();
      k++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] w;
    int k;
    reset_L = 1'b0; init = 1'b1; ready_in = 1'b1;
    req = 1'b0; idx = 2'd0; prev_pop = 1'b0;
    hs_n = 0; hs_first = 0; hs_last = 0;
    for (int n = 0; n < 4; n++) pop_cnt[n] = 0;
    drive();
    #2;
    check("rst_pop", pop_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_cnt", contador, 0);
    check("rst_cnt_valid", contador_valid, 0);
    check("rst_err", err_route, 0);

    // single word from FIFO0
    fq[0].push_back(10'h001);
    drive();
    @(posedge clk); #1;
    reset_L = 1'b1;
    cycle();
    cycle();
    check("init_no_pop", s_pop, 0);
    check("state_init", dut.state, ST_INIT);
    exp_q.push_back(10'h001);
    init = 1'b0;
    drain(20);
    cycle();
    check("pop0_once", pop_cnt[0], 1);
    check("pop_others", pop_cnt[1] + pop_cnt[2] + pop_cnt[3], 0);
    check("state_idle", dut.state, ST_IDLE);

    // two words in every FIFO
    init = 1'b1;
    cycle();
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 2; j++) begin
        w = 10'(n * 256 + j * 16 + n);
        fq[n].push_back(w);
      end
`ifdef TL_DRAIN_RR_EN
    for (int j = 0; j < 2; j++)
      for (int n = 0; n < 4; n++) exp_q.push_back(10'(n * 256 + j * 16 + n));
`else
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 2; j++) exp_q.push_back(10'(n * 256 + j * 16 + n));
`endif
    drive();
    hs_n = 0;
    init = 1'b0;
    drain(40);
    check("hs_count", hs_n, 8);
    check("gapless_span", hs_last - hs_first, 7);

    // backpressure
    init = 1'b1;
    cycle();
    fq[1].push_back(10'h100); fq[1].push_back(10'h111); fq[1].push_back(10'h122);
    exp_q.push_back(10'h100); exp_q.push_back(10'h111); exp_q.push_back(10'h122);
    drive();
    ready_in = 1'b0;
    init = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (!s_valid && k < 10);
    check("bp_valid", s_valid, 1);
    check("bp_data0", s_data, 10'h100);
    repeat (3) begin
      cycle();
      check("bp_hold_data", s_data, 10'h100);
      check("bp_hold_valid", s_valid, 1);
      check("bp_no_pop", s_pop, 0);
    end
    ready_in = 1'b1;
    cycle();
    check("bp_resume_pop", s_pop, 4'b0010);
    drain(20);

    // counter wrap and read
    init = 1'b1;
    cycle();
    for (int j = 0; j < 33; j++) begin
      fq[2].push_back(10'(512 + j));
      exp_q.push_back(10'(512 + j));
    end
    drive();
    init = 1'b0;
    drain(100);
    req = 1'b1; idx = 2'd2;
    cycle();
    check("cnt_no_early", s_cv, 0);
    req = 1'b0;
    cycle();
    check("cnt_valid", s_cv, 1);
    check("cnt_wrap", s_cnt, 1);
    cycle();
    check("cnt_pulse", s_cv, 0);
    req = 1'b1; idx = 2'd0;
    cycle();
    req = 1'b0;
    cycle();
    check("cnt_idx0_valid", s_cv, 1);
    check("cnt_idx0", s_cnt, 0);
    fq[2].push_back(10'h2f0);
    exp_q.push_back(10'h2f0);
    drive();
    cycle();
    req = 1'b1; idx = 2'd2;
    cycle();
    check("cnt_same_pop", s_pop, 4'b0100);
    req = 1'b0;
    cycle();
    check("cnt_pre_inc", s_cnt, 1);
    req = 1'b1;
    cycle();
    req = 1'b0;
    cycle();
    check("cnt_post_inc", s_cnt, 2);
    drain(20);

    // routing error
    init = 1'b1;
    cycle();
    fq[1].push_back(10'h301); fq[1].push_back(10'h102);
    exp_q.push_back(10'h301); exp_q.push_back(10'h102);
    drive();
    init = 1'b0;
    drain(20);
    check("err_set", err_route, 4'b0010);
    fq[0].push_back(10'h005);
    exp_q.push_back(10'h005);
    drive();
    drain(20);
    check("err_sticky", err_route, 4'b0010);
    init = 1'b1;
    cycle();
    cycle();
    check("err_init_clr", err_route, 0);

    // reset in the middle of a stream
    for (int j = 0; j < 6; j++) begin
      fq[3].push_back(10'(768 + 160 + j));
      exp_q.push_back(10'(768 + 160 + j));
    end
    drive();
    init = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (!s_valid && k < 10);
    check("mid_valid", s_valid, 1);
    req = 1'b1; idx = 2'd3;
    cycle();
    req = 1'b0;
    cycle();
    check("mid_cnt_nonzero", s_cnt != 0, 1);
    reset_L = 1'b0;
    #1;
    check("mrst_pop", pop_out, 0);
    check("mrst_valid", valid_out, 0);
    check("mrst_data", data_out, 0);
    check("mrst_cnt", contador, 0);
    check("mrst_cnt_valid", contador_valid, 0);
    check("mrst_err", err_route, 0);
    check("mrst_state", dut.state, ST_RESET);
    exp_q.delete();
    for (int n = 0; n < 4; n++) fq[n].delete();
    prev_pop = 1'b0;
    init = 1'b1;
    drive();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
